// File: rtl/counter_modn_cascade_pkg.sv
// rtl/counter_modn_cascade_pkg.sv - shared constants and helpers for the cascaded mod-N counter
package counter_modn_cascade_pkg;

  localparam int N_MIN      = 2;
  localparam int N_MAX      = 256;
  localparam int DIGITS_MAX = 8;

  // Bits needed to encode 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_modn_digit.sv
// rtl/counter_modn_digit.sv - one mod-N up/down digit with ripple step output
module counter_modn_digit #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_in,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_digit,
  output logic [W-1:0] digit,
  output logic         step_out
);

  localparam logic [W-1:0] MAX_D = W'(N - 1);

  logic [W-1:0] digit_q = '0;
  logic         at_wrap;

  assign at_wrap  = up ? (digit_q == MAX_D) : (digit_q == '0);
  assign step_out = step_in & at_wrap;
  assign digit    = digit_q;

  // Out-of-range load values saturate so a digit can never hold >= N.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else if (load) begin
      digit_q <= (load_digit > MAX_D) ? MAX_D : load_digit;
    end else if (step_in) begin
      if (at_wrap) digit_q <= up ? '0 : MAX_D;
      else         digit_q <= up ? (digit_q + W'(1)) : (digit_q - W'(1));
    end
  end

endmodule

// File: rtl/counter_modn_cascade.sv
// rtl/counter_modn_cascade.sv - DIGITS-wide cascaded mod-N up/down counter with tc and sticky ovf
module counter_modn_cascade
  import counter_modn_cascade_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = 4,
  parameter int W      = clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
  input  logic                clr_ovf,
  output logic [DIGITS*W-1:0] out,
  output logic                tc,
  output logic                ovf
);

  if (N < N_MIN || N > N_MAX || DIGITS < 1 || DIGITS > DIGITS_MAX || W < clog2(N)) begin : g_bad_param
    $error("counter_modn_cascade: illegal N, DIGITS or W");
  end

  logic [DIGITS:0] step;
  logic            ovf_q = 1'b0;

  assign step[0] = ce & ~load;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    counter_modn_digit #(.N(N), .W(W)) u_digit (
      .clk        (clk),
      .rst        (rst),
      .step_in    (step[k]),
      .up         (up),
      .load       (load),
      .load_digit (load_val[k*W +: W]),
      .digit      (out[k*W +: W]),
      .step_out   (step[k+1])
    );
  end

  // The step leaving the last digit is exactly the full-wrap condition.
  assign tc  = step[DIGITS];
  assign ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (tc)      ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_counter_modn_cascade.sv
// tb/tb_counter_modn_cascade.sv - vector, sequence and randomized checks of counter_modn_cascade
module tb_counter_modn_cascade;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=10, DIGITS=3
  logic        rst_a = 1'b1, ce_a = 1'b0, up_a = 1'b0, load_a = 1'b0, clr_a = 1'b0;
  logic [11:0] lv_a = '0;
  logic [11:0] out_a;
  logic        tc_a, ovf_a;

  counter_modn_cascade #(.N(10), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .up(up_a), .load(load_a), .load_val(lv_a),
    .clr_ovf(clr_a), .out(out_a), .tc(tc_a), .ovf(ovf_a)
  );

  // Instance B: N=7, DIGITS=2
  logic       rst_b = 1'b1, ce_b = 1'b0, up_b = 1'b0, load_b = 1'b0, clr_b = 1'b0;
  logic [5:0] lv_b = '0;
  logic [5:0] out_b;
  logic       tc_b, ovf_b;

  counter_modn_cascade #(.N(7), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .up(up_b), .load(load_b), .load_val(lv_b),
    .clr_ovf(clr_b), .out(out_b), .tc(tc_b), .ovf(ovf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    logic [11:0] r;
    r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  typedef struct {
    logic        rst, ce, up, load, clr;
    logic [11:0] lv;
    int          exp_out;
    logic        exp_tc, exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic r, c, u, l, cl, input logic [11:0] lv,
                              input int eo, input logic et, input logic ev);
    vec_t v;
    v.rst = r; v.ce = c; v.up = u; v.load = l; v.clr = cl; v.lv = lv;
    v.exp_out = eo; v.exp_tc = et; v.exp_ovf = ev;
    return v;
  endfunction

  task automatic drive_a(input logic r, c, u, l, cl, input logic [11:0] lv);
    @(negedge clk);
    rst_a = r; ce_a = c; up_a = u; load_a = l; clr_a = cl; lv_a = lv;
    #1;
  endtask

  vec_t vq[$];
  int   mv;
  logic movf, etc;
  logic [5:0] sat_lv;
  int   d0, d1;

  initial begin
    //           rst ce up ld clr lv        out  tc ovf
    vq.push_back(mk(1, 0, 0, 0, 0, 12'h000,   0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 12'h0F5,  95, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000,  94, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000,  93, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000,  92, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000,  91, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000,  90, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000,  89, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 12'h499, 499, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 1, 12'h777,   0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000, 999, 1, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 12'h000, 999, 0, 1));
    vq.push_back(mk(0, 1, 1, 0, 1, 12'h000,   0, 1, 1));
    vq.push_back(mk(0, 0, 1, 0, 1, 12'h000,   0, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 12'h123, 123, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000, 122, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 12'h000, 123, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 12'h000, 122, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive_a(vq[i].rst, vq[i].ce, vq[i].up, vq[i].load, vq[i].clr, vq[i].lv);
      chk($sformatf("vec%0d_tc", i), 32'(tc_a), 32'(vq[i].exp_tc));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i), 32'(out_a), 32'(dec3(vq[i].exp_out)));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf_a), 32'(vq[i].exp_ovf));
    end

    // Full 1000-step up count from reset.
    drive_a(1, 0, 1, 0, 0, 12'h000);
    @(posedge clk); #1;
    chk("cnt_reset_out", 32'(out_a), 32'(0));
    for (int i = 0; i < 1000; i++) begin
      drive_a(0, 1, 1, 0, 0, 12'h000);
      chk("cnt_out", 32'(out_a), 32'(dec3(i)));
      chk("cnt_tc", 32'(tc_a), 32'(i == 999));
      if (i == 500) chk("cnt_ovf_mid", 32'(ovf_a), 32'(0));
      @(posedge clk);
    end
    #1;
    chk("cnt_final_out", 32'(out_a), 32'(0));
    chk("cnt_final_ovf", 32'(ovf_a), 32'(1));

    // Reset with a carry pending at 009 abandons it.
    for (int i = 0; i < 9; i++) begin
      drive_a(0, 1, 1, 0, 0, 12'h000);
      @(posedge clk);
    end
    #1;
    chk("pend_out", 32'(out_a), 32'(dec3(9)));
    drive_a(1, 1, 1, 0, 0, 12'h000);
    @(posedge clk); #1;
    chk("pend_rst_out", 32'(out_a), 32'(0));
    chk("pend_rst_ovf", 32'(ovf_a), 32'(0));
    drive_a(0, 1, 1, 0, 0, 12'h000);
    @(posedge clk); #1;
    chk("pend_resume_out", 32'(out_a), 32'(dec3(1)));
    drive_a(0, 0, 1, 0, 0, 12'h000);

    // Randomized N=7, DIGITS=2 against an integer-modulo-49 model.
    mv = 0; movf = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rst_b  = (i == 0) || ($urandom_range(99) == 0);
      ce_b   = ($urandom_range(9) < 7);
      up_b   = $urandom_range(1);
      load_b = ($urandom_range(19) == 0);
      clr_b  = ($urandom_range(19) == 0);
      lv_b   = 6'($urandom);
      #1;
      etc = ce_b && !load_b && (up_b ? (mv == 48) : (mv == 0));
      chk("rnd_tc", 32'(tc_b), 32'(etc));
      @(posedge clk); #1;
      sat_lv = lv_b;
      d0 = (int'(sat_lv[2:0]) > 6) ? 6 : int'(sat_lv[2:0]);
      d1 = (int'(sat_lv[5:3]) > 6) ? 6 : int'(sat_lv[5:3]);
      if (rst_b)       mv = 0;
      else if (load_b) mv = d1 * 7 + d0;
      else if (ce_b)   mv = up_b ? (mv + 1) % 49 : (mv + 48) % 49;
      if (rst_b)      movf = 1'b0;
      else if (etc)   movf = 1'b1;
      else if (clr_b) movf = 1'b0;
      chk("rnd_out", 32'(out_b), 32'({3'(mv / 7), 3'(mv % 7)}));
      chk("rnd_ovf", 32'(ovf_b), 32'(movf));
      chk("rnd_digit_range", 32'((out_b[2:0] <= 3'd6) && (out_b[5:3] <= 3'd6)), 32'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
